mmu_feeder: RTL and testbench
=============================

MMU_FEEDER -- requirements
Module: mmu_feeder

Interface
REQ-001 Parameter: WIDTH, default 8, data width of operands and results.
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  host operand byte valid.
REQ-005 in_ready  output  1  feeder accepts an operand this cycle.
REQ-006 in_data  input  WIDTH  operand, order A00,A01,A10,A11,B00,B01,B10,B11.
REQ-007 relu_req  input  1  ReLU request, sampled on the accepted B11 beat.
REQ-008 clear  output  1  accumulator clear to the 2x2 array.
REQ-009 activation  output  1  ReLU enable to the array.
REQ-010 a_data0, a_data1, b_data0, b_data1  output  WIDTH each  skewed operand streams to the array.
REQ-011 c00, c01, c10, c11  input  WIDTH each  array results.
REQ-012 out_valid  output  1  result word valid.
REQ-013 out_ready  input  1  host accepts result word.
REQ-014 out_data  output  WIDTH  results, order c00,c01,c10,c11.

Function
REQ-015 FSM states SHALL be LOAD, CLEAR, FEED0, FEED1, FEED2, DRAIN, CAPTURE, OUTPUT.
REQ-016 LOAD: in_ready=1; each in_valid beat stores in_data at a 3-bit load index, which then increments.
REQ-017 On the beat accepted at index 7, the index SHALL wrap to 0 and the FSM SHALL go to CLEAR next cycle.
REQ-018 CLEAR: one cycle; clear=1; all a/b outputs 0.
REQ-019 FEED0: a_data0=A00, a_data1=0, b_data0=B00, b_data1=0.
REQ-020 FEED1: a_data0=A01, a_data1=A10, b_data0=B10, b_data1=B01.
REQ-021 FEED2: a_data0=0, a_data1=A11, b_data0=0, b_data1=B11.
REQ-022 DRAIN: all a/b outputs 0 for DRAIN_CYCLES=3 cycles (down-counter), then CAPTURE.
REQ-023 CAPTURE: one cycle; c00..c11 registered into a 4-entry result buffer.
REQ-024 Outside FEED0-FEED2, all a/b outputs SHALL be 0.
REQ-025 clear SHALL be 1 only in CLEAR.
REQ-026 in_ready SHALL be 0 in every state except LOAD.
REQ-027 in_valid outside LOAD SHALL be ignored with no state change.
REQ-028 OUTPUT: out_valid=1 and out_data=buffer[result index].
REQ-029 An out_valid&&out_ready beat SHALL advance the result index.
REQ-030 When out_valid=1 and out_ready=0, out_data SHALL hold stable.
REQ-031 After the 4th accepted word, the FSM SHALL return to LOAD and in_ready SHALL rise next cycle, never the same cycle.
REQ-032 Latency from the B11 beat to the first out_valid SHALL be 8 cycles.
REQ-033 Results SHALL pass through unmodified (no width change or rounding); activation is applied inside the array.

Reset
REQ-034 rst SHALL force LOAD, load and result indices 0, and the drain counter 0.
REQ-035 rst SHALL set the operand and result buffers to 0, clear=0, activation=0, all a/b outputs 0, out_valid=0, in_ready=1 (following cycle).
REQ-036 rst in any state, including mid-FEED or mid-OUTPUT, SHALL abandon the operation; partial loads SHALL be discarded.

Configuration
REQ-037 Macro MMU_FEEDER_RELU_EN defined: relu_req is latched on the B11 beat and drives activation from CLEAR through OUTPUT; activation=0 in LOAD.
REQ-038 Macro MMU_FEEDER_RELU_EN undefined: activation SHALL be tied to 0 and relu_req ignored; ports are unchanged.

Structure
REQ-039 Shared package mmu_pkg SHALL hold the FSM state enum, DRAIN_CYCLES, and the operand-order index constants.
REQ-040 Sub-module mmu_skew_mux SHALL hold the combinational operand selection from FSM state to a/b outputs.

Verification
REQ-041 Load A=[1,2;3,4], B=[5,6;7,8], out_ready=1 -> out_data 19,22,43,50 on consecutive cycles; clear pulses exactly once.
REQ-042 Same load with out_ready toggled 1,0,0,1,... -> same four words in order, each held while stalled, none lost or duplicated.
REQ-043 With the macro, A=I, B=[-3,2;4,-5], relu_req=1 -> activation=1 during compute; the array returns 0,2,4,0, forwarded unchanged.
REQ-044 Without the macro, same stimulus -> activation=0; outputs 0xFD,0x02,0x04,0xFB.
REQ-045 rst asserted in FEED1 after one complete job -> all outputs at reset values; a fresh 8-beat load then yields correct results.
REQ-046 in_valid held high during CLEAR..OUTPUT -> in_ready=0, no beats consumed; the next job loads only after the 4th result is accepted.

Source files
------------

// File: rtl/mmu_pkg.sv
// Shared definitions for the 2x2 matrix-multiply feeder: FSM states, drain length
// and the position of each operand within the eight-beat load sequence.
package mmu_pkg;

    typedef enum logic [2:0] {
        ST_LOAD    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_FEED0   = 3'd2,
        ST_FEED1   = 3'd3,
        ST_FEED2   = 3'd4,
        ST_DRAIN   = 3'd5,
        ST_CAPTURE = 3'd6,
        ST_OUTPUT  = 3'd7
    } state_t;

    // Cycles of zero input after FEED2 so the far corner of the array settles.
    localparam int DRAIN_CYCLES = 3;
    localparam logic [1:0] DRAIN_LOAD = 2'(DRAIN_CYCLES - 1);

    localparam logic [2:0] IDX_A00 = 3'd0;
    localparam logic [2:0] IDX_A01 = 3'd1;
    localparam logic [2:0] IDX_A10 = 3'd2;
    localparam logic [2:0] IDX_A11 = 3'd3;
    localparam logic [2:0] IDX_B00 = 3'd4;
    localparam logic [2:0] IDX_B01 = 3'd5;
    localparam logic [2:0] IDX_B10 = 3'd6;
    localparam logic [2:0] IDX_B11 = 3'd7;

    localparam int NUM_OPERANDS = 8;
    localparam int NUM_RESULTS  = 4;
    localparam logic [1:0] LAST_RESULT = 2'd3;

endpackage

// File: rtl/mmu_skew_mux.sv
// Combinational operand skew: picks which stored operand enters each array edge
// port in each FEED state; every port reads 0 outside FEED0..FEED2.
module mmu_skew_mux
    import mmu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  state_t           state,
    input  logic [WIDTH-1:0] a00,
    input  logic [WIDTH-1:0] a01,
    input  logic [WIDTH-1:0] a10,
    input  logic [WIDTH-1:0] a11,
    input  logic [WIDTH-1:0] b00,
    input  logic [WIDTH-1:0] b01,
    input  logic [WIDTH-1:0] b10,
    input  logic [WIDTH-1:0] b11,
    output logic [WIDTH-1:0] a_data0,
    output logic [WIDTH-1:0] a_data1,
    output logic [WIDTH-1:0] b_data0,
    output logic [WIDTH-1:0] b_data1
);

    always_comb begin
        a_data0 = '0;
        a_data1 = '0;
        b_data0 = '0;
        b_data1 = '0;
        case (state)
            ST_FEED0: begin
                a_data0 = a00;
                b_data0 = b00;
            end
            // Row 1 and column 1 run one cycle behind row 0 / column 0.
            ST_FEED1: begin
                a_data0 = a01;
                a_data1 = a10;
                b_data0 = b10;
                b_data1 = b01;
            end
            ST_FEED2: begin
                a_data1 = a11;
                b_data1 = b11;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mmu_feeder.sv
// Feeder for an external 2x2 systolic array: loads A/B, streams skewed operands,
// captures the four results and returns them. Optional ReLU via MMU_FEEDER_RELU_EN.
module mmu_feeder
    import mmu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             relu_req,
    output logic             clear,
    output logic             activation,
    output logic [WIDTH-1:0] a_data0,
    output logic [WIDTH-1:0] a_data1,
    output logic [WIDTH-1:0] b_data0,
    output logic [WIDTH-1:0] b_data1,
    input  logic [WIDTH-1:0] c00,
    input  logic [WIDTH-1:0] c01,
    input  logic [WIDTH-1:0] c10,
    input  logic [WIDTH-1:0] c11,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    state_t           state;
    state_t           state_next;
    logic [2:0]       load_idx;
    logic [1:0]       res_idx;
    logic [1:0]       drain_cnt;
    logic [WIDTH-1:0] opnd [NUM_OPERANDS];
    logic [WIDTH-1:0] res  [NUM_RESULTS];
    logic             in_fire;
    logic             out_fire;
    logic             last_beat;

    // Valid/ready: a beat transfers on a rising edge where valid and ready are both 1.
    assign in_fire   = (state == ST_LOAD) && in_valid;
    assign out_fire  = (state == ST_OUTPUT) && out_ready;
    assign last_beat = in_fire && (load_idx == IDX_B11);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_LOAD;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        clear      = 1'b0;
        out_valid  = 1'b0;
        case (state)
            ST_LOAD: begin
                in_ready = 1'b1;
                if (last_beat) begin
                    state_next = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                clear      = 1'b1;
                state_next = ST_FEED0;
            end
            ST_FEED0: state_next = ST_FEED1;
            ST_FEED1: state_next = ST_FEED2;
            ST_FEED2: state_next = ST_DRAIN;
            ST_DRAIN: begin
                if (drain_cnt == 2'd0) begin
                    state_next = ST_CAPTURE;
                end
            end
            ST_CAPTURE: state_next = ST_OUTPUT;
            ST_OUTPUT: begin
                out_valid = 1'b1;
                if (out_fire && (res_idx == LAST_RESULT)) begin
                    state_next = ST_LOAD;
                end
            end
            default: state_next = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            load_idx  <= '0;
            res_idx   <= '0;
            drain_cnt <= '0;
            for (int i = 0; i < NUM_OPERANDS; i++) begin
                opnd[i] <= '0;
            end
            for (int i = 0; i < NUM_RESULTS; i++) begin
                res[i] <= '0;
            end
        end else begin
            if (in_fire) begin
                opnd[load_idx] <= in_data;
                load_idx       <= load_idx + 3'd1;
            end
            if (state == ST_FEED2) begin
                drain_cnt <= DRAIN_LOAD;
            end else if ((state == ST_DRAIN) && (drain_cnt != 2'd0)) begin
                drain_cnt <= drain_cnt - 2'd1;
            end
            if (state == ST_CAPTURE) begin
                res[0] <= c00;
                res[1] <= c01;
                res[2] <= c10;
                res[3] <= c11;
            end
            if (out_fire) begin
                res_idx <= res_idx + 2'd1;
            end
        end
    end

    assign out_data = res[res_idx];

`ifdef MMU_FEEDER_RELU_EN
    logic relu_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            relu_q <= 1'b0;
        end else if (last_beat) begin
            relu_q <= relu_req;
        end
    end

    assign activation = relu_q && (state != ST_LOAD);
`else
    logic unused_relu_req;

    assign unused_relu_req = relu_req;
    assign activation      = 1'b0;
`endif

    mmu_skew_mux #(
        .WIDTH(WIDTH)
    ) u_skew_mux (
        .state  (state),
        .a00    (opnd[IDX_A00]),
        .a01    (opnd[IDX_A01]),
        .a10    (opnd[IDX_A10]),
        .a11    (opnd[IDX_A11]),
        .b00    (opnd[IDX_B00]),
        .b01    (opnd[IDX_B01]),
        .b10    (opnd[IDX_B10]),
        .b11    (opnd[IDX_B11]),
        .a_data0(a_data0),
        .a_data1(a_data1),
        .b_data0(b_data0),
        .b_data1(b_data1)
    );

endmodule

// File: tb/tb_mmu_feeder.sv
// Bench for mmu_feeder: a behavioural 2x2 output-stationary array closes the loop,
// a scoreboard queue holds hand-computed result words checked by a monitor.
module tb_mmu_feeder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         relu_req;
    logic         clear;
    logic         activation;
    logic [W-1:0] a_data0, a_data1, b_data0, b_data1;
    logic [W-1:0] c00, c01, c10, c11;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;

    int errors = 0;
    int checks = 0;
    int clear_cnt = 0;
    logic stall_mode = 1'b0;
    int pat_cnt = 0;
    logic [W-1:0] exp_q[$];

    always #5 clk = ~clk;

    mmu_feeder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .relu_req  (relu_req),
        .clear     (clear),
        .activation(activation),
        .a_data0   (a_data0),
        .a_data1   (a_data1),
        .b_data0   (b_data0),
        .b_data1   (b_data1),
        .c00       (c00),
        .c01       (c01),
        .c10       (c10),
        .c11       (c11),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    // Output-stationary 2x2 array: a moves right, b moves down, one register per hop.
    logic [W-1:0] acc [4];
    logic [W-1:0] a_d0, a_d1, b_d0, b_d1;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) acc[i] <= '0;
            a_d0 <= '0; a_d1 <= '0; b_d0 <= '0; b_d1 <= '0;
        end else begin
            if (clear) begin
                for (int i = 0; i < 4; i++) acc[i] <= '0;
            end else begin
                acc[0] <= acc[0] + a_data0 * b_data0;
                acc[1] <= acc[1] + a_d0 * b_data1;
                acc[2] <= acc[2] + a_data1 * b_d0;
                acc[3] <= acc[3] + a_d1 * b_d1;
            end
            a_d0 <= a_data0; a_d1 <= a_data1; b_d0 <= b_data0; b_d1 <= b_data1;
        end
    end

    function automatic logic [W-1:0] relu_f(input logic act, input logic [W-1:0] v);
        return (act && v[W-1]) ? '0 : v;
    endfunction

    assign c00 = relu_f(activation, acc[0]);
    assign c01 = relu_f(activation, acc[1]);
    assign c10 = relu_f(activation, acc[2]);
    assign c11 = relu_f(activation, acc[3]);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // out_ready pattern driven well after the edge: all-ones, or 1,0,0 repeating.
    always @(posedge clk) begin
        #2;
        if (stall_mode) begin
            out_ready = (pat_cnt % 3 == 0);
            pat_cnt++;
        end else begin
            out_ready = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (clear) clear_cnt++;
    end

    // Monitor: pops the scoreboard on every accepted word, checks holding while stalled.
    logic         stalled = 1'b0;
    logic [W-1:0] held;

    always @(negedge clk) begin
        logic [W-1:0] exp_w;
        if (!rst && out_valid) begin
            check("in_ready_while_output", {31'd0, in_ready}, 32'd0);
            if (stalled) check("out_data_hold", {24'd0, out_data}, {24'd0, held});
            if (out_ready) begin
                stalled = 1'b0;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got %0h expected none", out_data);
                end else begin
                    exp_w = exp_q.pop_front();
                    check("out_data", {24'd0, out_data}, {24'd0, exp_w});
                end
            end else begin
                stalled = 1'b1;
                held    = out_data;
            end
        end else begin
            stalled = 1'b0;
        end
    end

    task automatic push_exp(input logic [W-1:0] r0, r1, r2, r3);
        exp_q.push_back(r0);
        exp_q.push_back(r1);
        exp_q.push_back(r2);
        exp_q.push_back(r3);
    endtask

    // Returns 1 ns after the edge that accepted the B11 beat.
    task automatic load_job(input logic [W-1:0] a00, a01, a10, a11, b00, b01, b10, b11,
                            input logic relu, input logic keep, input logic [W-1:0] next_data);
        logic [W-1:0] v [8];
        int n;
        v = '{a00, a01, a10, a11, b00, b01, b10, b11};
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = v[i];
            relu_req = (i == 7) ? relu : 1'b0;
            n = 0;
            while (!in_ready) begin
                if (n >= 300) begin
                    $display("FAIL load_timeout: got in_ready=0 expected 1 within 300 cycles");
                    $fatal(1, "load stalled");
                end
                @(posedge clk); #1;
                n++;
            end
            @(posedge clk); #1;
        end
        relu_req = 1'b0;
        if (keep) in_data = next_data;
        else      in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", exp_q.size(), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic check_idle();
        check("idle_in_ready", {31'd0, in_ready}, 32'd1);
        check("idle_out_valid", {31'd0, out_valid}, 32'd0);
        check("idle_clear", {31'd0, clear}, 32'd0);
        check("idle_activation", {31'd0, activation}, 32'd0);
        check("idle_a_data0", {24'd0, a_data0}, 32'd0);
        check("idle_a_data1", {24'd0, a_data1}, 32'd0);
        check("idle_b_data0", {24'd0, b_data0}, 32'd0);
        check("idle_b_data1", {24'd0, b_data1}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic exp_act;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; relu_req = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_idle();
        rst = 1'b0;
        @(posedge clk); #1;
        check_idle();

        // A=[1,2;3,4] B=[5,6;7,8], free-flowing output, latency and single clear.
        clear_cnt = 0;
        push_exp(8'd19, 8'd22, 8'd43, 8'd50);
        load_job(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 1'b0, 1'b0, 8'd0);
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", lat, 32'd8);
        wait_drain();
        check("clear_pulses", clear_cnt, 32'd1);

        // Same job with out_ready 1,0,0,...
        stall_mode = 1'b1;
        pat_cnt = 0;
        push_exp(8'd19, 8'd22, 8'd43, 8'd50);
        load_job(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 1'b0, 1'b0, 8'd0);
        wait_drain();
        stall_mode = 1'b0;

        // A=I, B=[-3,2;4,-5] with a ReLU request.
`ifdef MMU_FEEDER_RELU_EN
        exp_act = 1'b1;
        push_exp(8'h00, 8'h02, 8'h04, 8'h00);
`else
        exp_act = 1'b0;
        push_exp(8'hFD, 8'h02, 8'h04, 8'hFB);
`endif
        load_job(8'd1, 8'd0, 8'd0, 8'd1, 8'hFD, 8'h02, 8'h04, 8'hFB, 1'b1, 1'b0, 8'd0);
        check("clear_in_clear", {31'd0, clear}, 32'd1);
        check("activation_clear", {31'd0, activation}, {31'd0, exp_act});
        @(posedge clk); #1;
        check("activation_feed0", {31'd0, activation}, {31'd0, exp_act});
        wait_drain();
        check("activation_load", {31'd0, activation}, 32'd0);

        // in_valid stays high (next job's A00) through the whole computation.
        push_exp(8'd70, 8'd100, 8'd150, 8'd220);
        load_job(8'd10, 8'd20, 8'd30, 8'd40, 8'd1, 8'd2, 8'd3, 8'd4, 1'b0, 1'b1, 8'd100);
        for (int i = 0; i < 8; i++) begin
            check("in_ready_busy", {31'd0, in_ready}, 32'd0);
            @(posedge clk); #1;
        end
        push_exp(8'd44, 8'd144, 8'd4, 8'd7);
        load_job(8'd100, 8'd100, 8'd1, 8'd2, 8'd2, 8'd1, 8'd1, 8'd3, 1'b0, 1'b0, 8'd0);
        wait_drain();

        // Abort in FEED1, then a fresh job.
        load_job(8'd5, 8'd6, 8'd7, 8'd8, 8'd1, 8'd2, 8'd3, 8'd4, 1'b0, 1'b0, 8'd0);
        @(posedge clk); #1;
        check("feed0_a_data0", {24'd0, a_data0}, 32'd5);
        check("feed0_a_data1", {24'd0, a_data1}, 32'd0);
        check("feed0_b_data0", {24'd0, b_data0}, 32'd1);
        check("feed0_b_data1", {24'd0, b_data1}, 32'd0);
        @(posedge clk); #1;
        check("feed1_a_data0", {24'd0, a_data0}, 32'd6);
        check("feed1_a_data1", {24'd0, a_data1}, 32'd7);
        check("feed1_b_data0", {24'd0, b_data0}, 32'd3);
        check("feed1_b_data1", {24'd0, b_data1}, 32'd2);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_idle();
        push_exp(8'd2, 8'd4, 8'd10, 8'd14);
        load_job(8'd2, 8'd0, 8'd1, 8'd3, 8'd1, 8'd2, 8'd3, 8'd4, 1'b0, 1'b0, 8'd0);
        wait_drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
